// File: rtl/hpu_pkg.sv
// Shared widths and state encoding for the hypervector stream datapath.
package hpu_pkg;

    localparam int unsigned IN_W_DEF   = 1024;
    localparam int unsigned OUT_W_DEF  = 64;
    localparam int unsigned RATIO_DEF  = IN_W_DEF / OUT_W_DEF;
    localparam int unsigned BEAT_W_DEF = $clog2(RATIO_DEF);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/stream_downsizer_if.sv
// Valid/ready stream bundle; master drives payload, slave drives ready.
interface stream_downsizer_if
    import hpu_pkg::*;
#(
    parameter int unsigned DATA_W = OUT_W_DEF
) ();

    logic              valid;
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/stream_downsizer.sv
// Replays each wide stream word as RATIO little-endian narrow beats at full rate,
// and counts completed wide words.
module stream_downsizer
    import hpu_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_downsizer_if.slave    s,
    stream_downsizer_if.master   m,
    output logic [OUT_W/8-1:0]   m_strb,
    output logic [15:0]          word_cnt
);

    localparam int unsigned RATIO  = IN_W / OUT_W;
    localparam int unsigned BEAT_W = $clog2(RATIO);

    if ((IN_W % OUT_W) != 0 || (OUT_W % 8) != 0 || RATIO < 2 ||
        (RATIO & (RATIO - 1)) != 0) begin : g_param_check
        $error("stream_downsizer: IN_W/OUT_W must be a power of two >= 2, OUT_W a multiple of 8");
    end

    state_e            state;
    logic [IN_W-1:0]   hold;
    logic              held_last;
    logic [BEAT_W-1:0] beat;
    logic              beat_end_c;

    assign beat_end_c = (beat == BEAT_W'(RATIO - 1));

    // Wide side is free when idle or when the final beat hands off this cycle.
    assign s.ready = (state == ST_IDLE) | ((state == ST_SEND) & m.ready & beat_end_c);

    // Beat 0 sits in the low slice; the hold register shifts down per beat.
    assign m.valid = (state == ST_SEND);
    assign m.data  = hold[OUT_W-1:0];
    assign m.last  = held_last & beat_end_c;
    assign m_strb  = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold      <= '0;
            held_last <= 1'b0;
            beat      <= '0;
            word_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s.valid) begin
                        hold      <= s.data;
                        held_last <= s.last;
                        beat      <= '0;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (m.ready) begin
                        if (beat_end_c) begin
                            word_cnt <= word_cnt + 16'd1;
                            if (s.valid) begin
                                hold      <= s.data;
                                held_last <= s.last;
                                beat      <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            hold <= hold >> OUT_W;
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
